// File: rtl/eeg_pea_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// eeg_pea_pkg : feeder FSM encoding and default widths shared with the PE.
// Rev 1.0
// -----------------------------------------------------------------------------
package eeg_pea_pkg;

   localparam int unsigned DEF_DATA_ACT_DW = 8;
   localparam int unsigned DEF_DATA_WEI_DW = 8;
   localparam int unsigned DEF_ARAM_ADD_AW = 10;
   localparam int unsigned DEF_CONV_WEI_DW = 3;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_WLD   = 4'b0010,
      ST_RUN   = 4'b0100,
      ST_DRAIN = 4'b1000
   } feed_state_e;

endpackage
`default_nettype wire

// File: rtl/eeg_feed_nz_pick.sv
`default_nettype none
// -----------------------------------------------------------------------------
// eeg_feed_nz_pick : lowest set mask bit strictly above idx_i; none_o if absent.
// Rev 1.0
// -----------------------------------------------------------------------------
module eeg_feed_nz_pick #(
   parameter int unsigned IDX_W = 3
) (
   input  logic [(1<<IDX_W)-1:0] mask_i,
   input  logic [IDX_W-1:0]      idx_i,
   output logic [IDX_W-1:0]      nxt_o,
   output logic                  none_o
);

   localparam int NW = 1 << IDX_W;

   // Descending scan so the last hit written is the lowest qualifying index.
   always_comb begin
      nxt_o  = '0;
      none_o = 1'b1;
      for (int i = NW - 1; i >= 0; i--) begin
         if (mask_i[i] && (i > int'(idx_i))) begin
            nxt_o  = IDX_W'(i);
            none_o = 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/eeg_pea_eng_feed.sv
`default_nettype none
// -----------------------------------------------------------------------------
// eeg_pea_eng_feed : loads a weight kernel, expands each activation into one PE
// beat per non-zero weight. EEG_FEED_ZSKIP_EN drops zero non-last activations.
// Rev 1.0
// -----------------------------------------------------------------------------
module eeg_pea_eng_feed
   import eeg_pea_pkg::*;
#(
   parameter int unsigned DATA_ACT_DW = DEF_DATA_ACT_DW,
   parameter int unsigned DATA_WEI_DW = DEF_DATA_WEI_DW,
   parameter int unsigned ARAM_ADD_AW = DEF_ARAM_ADD_AW,
   parameter int unsigned CONV_WEI_DW = DEF_CONV_WEI_DW
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   START,
   input  logic [CONV_WEI_DW-1:0] CFG_CONV_WEI,
   input  logic                   WLD_VLD,
   output logic                   WLD_RDY,
   input  logic [DATA_WEI_DW-1:0] WLD_DAT,
   input  logic                   AIN_VLD,
   output logic                   AIN_RDY,
   input  logic [DATA_ACT_DW-1:0] AIN_DAT,
   input  logic [ARAM_ADD_AW-1:0] AIN_ADD,
   input  logic                   AIN_LST,
   output logic                   DIN_VLD,
   input  logic                   DIN_RDY,
   output logic [DATA_ACT_DW-1:0] ACT_DAT,
   output logic [ARAM_ADD_AW-1:0] ACT_ADD,
   output logic [DATA_WEI_DW-1:0] WEI_DAT,
   output logic [CONV_WEI_DW-1:0] WEI_IDX,
   output logic                   ACT_LST,
   output logic                   WEI_LST,
   input  logic                   PE_IS_IDLE,
   output logic                   BUSY,
   output logic                   DONE
);

   localparam int NW = 1 << CONV_WEI_DW;

   feed_state_e            state_q, state_d;
   logic [CONV_WEI_DW-1:0] cfg_q, wcnt_q;
   logic [DATA_WEI_DW-1:0] wei_q [NW];
   logic [NW-1:0]          mask_q;
   logic                   last_seen_q;

   logic                   hv_q;
   logic [DATA_ACT_DW-1:0] h_act_q;
   logic [ARAM_ADD_AW-1:0] h_add_q;
   logic                   h_lst_q;
   logic [CONV_WEI_DW-1:0] h_idx_q;

   logic                   din_vld_q, act_lst_q, wei_lst_q, done_q;
   logic [DATA_ACT_DW-1:0] act_dat_q;
   logic [ARAM_ADD_AW-1:0] act_add_q;
   logic [DATA_WEI_DW-1:0] wei_dat_q;
   logic [CONV_WEI_DW-1:0] wei_idx_q;

   logic st_idle, st_wld, st_run, st_drain;
   logic wld_acc, ain_acc, ain_emit, out_en, src_v, beat_mv, fin_mv, nz_none;
   logic [CONV_WEI_DW-1:0] s_idx, nxt_idx;

   assign st_idle  = (state_q == ST_IDLE);
   assign st_wld   = (state_q == ST_WLD);
   assign st_run   = (state_q == ST_RUN);
   assign st_drain = (state_q == ST_DRAIN);

`ifdef EEG_FEED_ZSKIP_EN
   assign ain_emit = AIN_LST | (AIN_DAT != '0);
`else
   assign ain_emit = 1'b1;
`endif

   // With an empty hold the incoming activation supplies idx 0 directly.
   assign s_idx = hv_q ? h_idx_q : '0;

   eeg_feed_nz_pick #(
      .IDX_W (CONV_WEI_DW)
   ) u_pick (
      .mask_i (mask_q),
      .idx_i  (s_idx),
      .nxt_o  (nxt_idx),
      .none_o (nz_none)
   );

   assign out_en  = ~din_vld_q | DIN_RDY;
   assign fin_mv  = st_run & hv_q & out_en & nz_none;
   assign AIN_RDY = st_run & (~hv_q | fin_mv) & ~last_seen_q;
   assign ain_acc = AIN_VLD & AIN_RDY;
   assign src_v   = st_run & (hv_q | (ain_acc & ain_emit));
   assign beat_mv = src_v & out_en;
   assign WLD_RDY = st_wld;
   assign wld_acc = WLD_VLD & st_wld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (START) state_d = ST_WLD;
         ST_WLD:   if (wld_acc && (wcnt_q == cfg_q)) state_d = ST_RUN;
         ST_RUN:   if (din_vld_q && DIN_RDY && act_lst_q && wei_lst_q) state_d = ST_DRAIN;
         ST_DRAIN: if (PE_IS_IDLE) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_q  <= '0;
         wcnt_q <= '0;
         mask_q <= '0;
         for (int i = 0; i < NW; i++) wei_q[i] <= '0;
      end else if (st_idle && START) begin
         cfg_q  <= CFG_CONV_WEI;
         wcnt_q <= '0;
         mask_q <= '0;
      end else if (wld_acc) begin
         wei_q[wcnt_q]  <= WLD_DAT;
         mask_q[wcnt_q] <= (WLD_DAT != '0) | (wcnt_q == '0);
         wcnt_q         <= wcnt_q + CONV_WEI_DW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    last_seen_q <= 1'b0;
      else if (st_idle)              last_seen_q <= 1'b0;
      else if (ain_acc && AIN_LST)   last_seen_q <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hv_q    <= 1'b0;
         h_act_q <= '0;
         h_add_q <= '0;
         h_lst_q <= 1'b0;
         h_idx_q <= '0;
      end else if (!st_run) begin
         hv_q <= 1'b0;
      end else begin
         if (hv_q && out_en) begin
            if (nz_none) hv_q    <= 1'b0;
            else         h_idx_q <= nxt_idx;
         end
         if (ain_acc && ain_emit) begin
            h_act_q <= AIN_DAT;
            h_add_q <= AIN_ADD;
            h_lst_q <= AIN_LST;
            // Park at idx 0 if the output slot is taken, else resume after the bypassed beat.
            if (hv_q || !out_en) begin
               hv_q    <= 1'b1;
               h_idx_q <= '0;
            end else if (!nz_none) begin
               hv_q    <= 1'b1;
               h_idx_q <= nxt_idx;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_vld_q <= 1'b0;
         act_dat_q <= '0;
         act_add_q <= '0;
         wei_dat_q <= '0;
         wei_idx_q <= '0;
         act_lst_q <= 1'b0;
         wei_lst_q <= 1'b0;
      end else if (out_en) begin
         din_vld_q <= beat_mv;
         if (beat_mv) begin
            act_dat_q <= hv_q ? h_act_q : AIN_DAT;
            act_add_q <= hv_q ? h_add_q : AIN_ADD;
            act_lst_q <= hv_q ? h_lst_q : AIN_LST;
            wei_dat_q <= wei_q[s_idx];
            wei_idx_q <= s_idx;
            wei_lst_q <= nz_none;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) done_q <= 1'b0;
      else        done_q <= st_drain & PE_IS_IDLE;
   end

   assign DIN_VLD = din_vld_q;
   assign ACT_DAT = act_dat_q;
   assign ACT_ADD = act_add_q;
   assign WEI_DAT = wei_dat_q;
   assign WEI_IDX = wei_idx_q;
   assign ACT_LST = act_lst_q;
   assign WEI_LST = wei_lst_q;
   assign BUSY    = ~st_idle;
   assign DONE    = done_q;

endmodule
`default_nettype wire
